// File: rtl/myproject_mul_pkg.sv
// Shared constants and the sign-saturation helper for the myproject_mul pipeline.
// Saturation is only instantiated when MYPROJECT_MUL_SAT_EN is defined.
package myproject_mul_pkg;

  localparam int MUL_MODE_MUL = 0;
  localparam int MUL_MODE_MAC = 1;

  // Working width wide enough for a 64-bit result plus one guard bit.
  localparam int SAT_W = 65;

  function automatic logic signed [SAT_W-1:0] sat_sign(input logic signed [SAT_W-1:0] v,
                                                       input int w);
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    hi = (SAT_W'(1) <<< (w - 1)) - SAT_W'(1);
    lo = -hi - SAT_W'(1);
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/myproject_mul_pipe_sat.sv
// Signed width reduction: two's-complement wrap by default, clamp to the
// output range when MYPROJECT_MUL_SAT_EN is defined.
module myproject_mul_pipe_sat
  import myproject_mul_pkg::*;
#(
  parameter int IN_W  = 25,
  parameter int OUT_W = 25
) (
  input  logic signed [IN_W-1:0]  din_i,
  output logic signed [OUT_W-1:0] dout_o
);

  logic signed [SAT_W-1:0] ext;
  logic signed [SAT_W-1:0] res;
  logic                    unused_res_hi;

  assign ext = SAT_W'(din_i);

`ifdef MYPROJECT_MUL_SAT_EN
  assign res = sat_sign(ext, OUT_W);
`else
  assign res = ext;
`endif

  assign dout_o        = res[OUT_W-1:0];
  assign unused_res_hi = ^res[SAT_W-1:OUT_W];

endmodule

// File: rtl/myproject_mul_pipe.sv
// Pipelined signed multiplier / multiply-accumulate with valid/ready handshake.
// Define MYPROJECT_MUL_SAT_EN to saturate width reduction and accumulation.
module myproject_mul_pipe
  import myproject_mul_pkg::*;
#(
  parameter int din0_WIDTH = 16,
  parameter int din1_WIDTH = 9,
  parameter int dout_WIDTH = 25,
  parameter int NUM_STAGE  = 3,
  parameter int MODE       = 0
) (
  input  logic                         ap_clk,
  input  logic                         ap_rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [din0_WIDTH-1:0] din0,
  input  logic signed [din1_WIDTH-1:0] din1,
  input  logic                         in_last,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [dout_WIDTH-1:0] dout
);

  localparam int PROD_W = din0_WIDTH + din1_WIDTH;
  localparam int DLY    = NUM_STAGE - 1;

  logic                         adv;
  logic signed [PROD_W-1:0]     prod_p0;
  logic signed [PROD_W-1:0]     prod_fin;
  logic                         vld_fin;
  logic                         last_fin;
  logic signed [dout_WIDTH-1:0] red_fin;
  logic signed [dout_WIDTH-1:0] sum;
  logic signed [dout_WIDTH-1:0] dout_q, dout_d;
  logic signed [dout_WIDTH-1:0] acc_q, acc_d;
  logic                         out_valid_q, out_valid_d;

  // The whole pipe freezes while a result waits on downstream.
  assign adv      = !(out_valid_q && !out_ready);
  assign in_ready = adv;
  assign prod_p0  = PROD_W'(din0) * PROD_W'(din1);

  // Stage p0 -> p(NUM_STAGE-1): full-width product delay line
  if (DLY == 0) begin : g_nodly
    assign prod_fin = prod_p0;
    assign vld_fin  = in_valid;
    assign last_fin = in_last;
  end else begin : g_dly
    logic [DLY-1:0]           vld_q;
    logic [DLY-1:0]           last_q;
    logic signed [PROD_W-1:0] prod_q [DLY];

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
        vld_q <= '0;
      end else if (adv) begin
        vld_q[0] <= in_valid;
        for (int i = 1; i < DLY; i++) vld_q[i] <= vld_q[i-1];
      end
    end

    always_ff @(posedge ap_clk) begin
      if (adv) begin
        prod_q[0] <= prod_p0;
        last_q[0] <= in_last;
        for (int i = 1; i < DLY; i++) begin
          prod_q[i] <= prod_q[i-1];
          last_q[i] <= last_q[i-1];
        end
      end
    end

    assign prod_fin = prod_q[DLY-1];
    assign vld_fin  = vld_q[DLY-1];
    assign last_fin = last_q[DLY-1];
  end

  // Final stage: reduce to output width, optionally accumulate, register result
  myproject_mul_pipe_sat #(
    .IN_W (PROD_W),
    .OUT_W(dout_WIDTH)
  ) u_sat (
    .din_i (prod_fin),
    .dout_o(red_fin)
  );

`ifdef MYPROJECT_MUL_SAT_EN
  logic signed [SAT_W-1:0] sum_wide;
  logic signed [SAT_W-1:0] sum_sat;
  logic                    sum_clip;
  logic                    stick_q, stick_d;
  logic                    unused_sum_hi;

  assign sum_wide      = SAT_W'(acc_q) + SAT_W'(red_fin);
  assign sum_sat       = sat_sign(sum_wide, dout_WIDTH);
  assign sum_clip      = (sum_sat != sum_wide);
  assign unused_sum_hi = ^sum_sat[SAT_W-1:dout_WIDTH];
  // Once a group has hit a rail it stays there until its last beat.
  assign sum           = stick_q ? acc_q : sum_sat[dout_WIDTH-1:0];

  always_comb begin
    stick_d = stick_q;
    if (adv && vld_fin) stick_d = last_fin ? 1'b0 : (stick_q | sum_clip);
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) stick_q <= 1'b0;
    else           stick_q <= stick_d;
  end
`else
  assign sum = acc_q + red_fin;
`endif

  always_comb begin
    dout_d      = dout_q;
    acc_d       = acc_q;
    out_valid_d = out_valid_q;
    if (adv) begin
      out_valid_d = 1'b0;
      if (vld_fin) begin
        if (MODE == MUL_MODE_MAC) begin
          if (last_fin) begin
            dout_d      = sum;
            out_valid_d = 1'b1;
            acc_d       = '0;
          end else begin
            acc_d = sum;
          end
        end else begin
          dout_d      = red_fin;
          out_valid_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      dout_q      <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      dout_q      <= dout_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign dout      = dout_q;
  assign out_valid = out_valid_q;

endmodule

// File: doc/myproject_mul_pipe.md
MYPROJECT_MUL_PIPE -- requirements
Module: myproject_mul_pipe

Interface
REQ-001 SHALL have parameter din0_WIDTH, default 16: signed operand A width (2..32).
REQ-002 SHALL have parameter din1_WIDTH, default 9: signed operand B width (2..32).
REQ-003 SHALL have parameter dout_WIDTH, default 25: signed result width (2..64).
REQ-004 SHALL have parameter NUM_STAGE, default 3: pipeline depth in cycles (1..8).
REQ-005 SHALL have parameter MODE, default 0: 0 = multiply, 1 = multiply-accumulate.
REQ-006 SHALL have port ap_clk, input, 1: sole clock; all state rising-edge.
REQ-007 SHALL have port ap_rst_n, input, 1: reset, asynchronous assert, active-low.
REQ-008 SHALL have port in_valid, input, 1: operand beat offered.
REQ-009 SHALL have port in_ready, output, 1: block accepts a beat this cycle.
REQ-010 SHALL have port din0, input, din0_WIDTH: signed operand A.
REQ-011 SHALL have port din1, input, din1_WIDTH: signed operand B.
REQ-012 SHALL have port in_last, input, 1: ends an accumulation group (ignored when MODE=0).
REQ-013 SHALL have port out_valid, output, 1: dout holds a result.
REQ-014 SHALL have port out_ready, input, 1: downstream accepts the result.
REQ-015 SHALL have port dout, output, dout_WIDTH: signed result.

Function
REQ-016 Beat accepted iff in_valid && in_ready; result transferred iff out_valid && out_ready.
REQ-017 in_ready SHALL equal !(out_valid && !out_ready); the whole pipeline advances only when in_ready=1.
REQ-018 Product SHALL be full signed din0*din1, width din0_WIDTH+din1_WIDTH, computed without loss.
REQ-019 Width reduction SHALL keep the low dout_WIDTH bits (sign-extend if wider), two's-complement wrap.
REQ-020 MODE=0: every accepted beat SHALL produce exactly one result, NUM_STAGE cycles later with no stall; throughput 1 beat/cycle.
REQ-021 MODE=1: each product SHALL add into a dout_WIDTH accumulator at the final stage; out_valid only for beats with in_last=1; dout = sum of group products; accumulator cleared after that beat.
REQ-022 MODE=1 single-beat group (in_last on first beat) SHALL output that product alone.
REQ-023 While stalled, dout, out_valid and all stage registers SHALL hold; no beat is lost or duplicated.
REQ-024 Results SHALL emerge in acceptance order; bubbles (in_valid=0) propagate as invalid stages.

Reset
REQ-025 ap_rst_n=0 SHALL immediately clear all stage valids, accumulator, out_valid=0, dout=0; in_ready=1 one cycle after deassert.
REQ-026 Reset mid-operation SHALL discard in-flight beats and partial accumulation; no result emitted for them.

Configuration
REQ-027 With MYPROJECT_MUL_SAT_EN defined, width reduction and accumulation SHALL saturate to [-2^(dout_WIDTH-1), 2^(dout_WIDTH-1)-1]; accumulator sticks at the rail until group end.
REQ-028 Without MYPROJECT_MUL_SAT_EN, REQ-019 wrap applies and no saturation logic is present.

Structure
REQ-029 Package myproject_mul_pkg SHALL hold MODE constants (MUL_MODE_MUL, MUL_MODE_MAC) and the sign-saturation function.
REQ-030 Width reduction/saturation SHALL be a sub-module myproject_mul_pipe_sat; pipeline and handshake stay in the top.

Verification
REQ-031 Defaults, MODE=0, out_ready=1: din0=-32768, din1=-256 -> dout=8388608 exactly 3 cycles later.
REQ-032 dout_WIDTH=16: 300*200 -> -5536 without macro; 32767 with MYPROJECT_MUL_SAT_EN.
REQ-033 MODE=1: (10,3),(-4,5),(7,7,last) -> single result 59; next group (2,2,last) -> 4.
REQ-034 Stream 1..20 squared, out_ready toggled pseudo-randomly -> 20 results in order, in_ready=0 exactly when out_valid&&!out_ready.
REQ-035 ap_rst_n pulsed low with 2 beats in flight and a partial MAC group -> no stale output; next group sums from 0.
